// File: rtl/triangle_setup_if.sv
// Setup-stage handshake bundle: vertex input side from the
// transform pipeline, setup results toward the rasterizer.
interface triangle_setup_if #(
  parameter int DATAWIDTH     = 12,
  parameter int SCREEN_WIDTH  = 320,
  parameter int SCREEN_HEIGHT = 320
);
  localparam int XW = $clog2(SCREEN_WIDTH);
  localparam int YW = $clog2(SCREEN_HEIGHT);

  logic signed [DATAWIDTH-1:0]   i_v0 [3];
  logic signed [DATAWIDTH-1:0]   i_v1 [3];
  logic signed [DATAWIDTH-1:0]   i_v2 [3];
  logic                          i_triangle_dv;
  logic                          i_triangle_last;
  logic                          o_ready;
  logic signed [DATAWIDTH-1:0]   o_v0 [3];
  logic signed [DATAWIDTH-1:0]   o_v1 [3];
  logic signed [DATAWIDTH-1:0]   o_v2 [3];
  logic signed [DATAWIDTH:0]     o_edge_a [3];
  logic signed [DATAWIDTH:0]     o_edge_b [3];
  logic signed [2*DATAWIDTH+2:0] o_area;
  logic [XW-1:0]                 o_bb_min_x;
  logic [XW-1:0]                 o_bb_max_x;
  logic [YW-1:0]                 o_bb_min_y;
  logic [YW-1:0]                 o_bb_max_y;
  logic                          o_dv;
  logic                          o_last;
  logic                          i_ready;
  logic                          o_done;
  logic [15:0]                   o_cull_count;

  modport master (
    output i_v0, i_v1, i_v2,
    output i_triangle_dv, i_triangle_last,
    output i_ready,
    input  o_ready,
    input  o_v0, o_v1, o_v2,
    input  o_edge_a, o_edge_b, o_area,
    input  o_bb_min_x, o_bb_max_x,
    input  o_bb_min_y, o_bb_max_y,
    input  o_dv, o_last, o_done,
    input  o_cull_count
  );

  modport slave (
    input  i_v0, i_v1, i_v2,
    input  i_triangle_dv, i_triangle_last,
    input  i_ready,
    output o_ready,
    output o_v0, o_v1, o_v2,
    output o_edge_a, o_edge_b, o_area,
    output o_bb_min_x, o_bb_max_x,
    output o_bb_min_y, o_bb_max_y,
    output o_dv, o_last, o_done,
    output o_cull_count
  );
endinterface

// File: rtl/triangle_setup.sv
// Triangle setup: area, edge coefficients, clamped bbox and
// culling between the transform pipeline and the rasterizer.
module triangle_setup #(
  parameter int DATAWIDTH     = 12,
  parameter int SCREEN_WIDTH  = 320,
  parameter int SCREEN_HEIGHT = 320,
  parameter int CULL_BACKFACE = 1
) (
  input  logic           clk,
  input  logic           rst,
  triangle_setup_if.slave bus
);
  localparam int DW = DATAWIDTH;
  localparam int XW = $clog2(SCREEN_WIDTH);
  localparam int YW = $clog2(SCREEN_HEIGHT);
  localparam int PW = 2*DW+2;
  localparam int AW = 2*DW+3;
  localparam logic signed [DW-1:0] XMAX = DW'(SCREEN_WIDTH-1);
  localparam logic signed [DW-1:0] YMAX = DW'(SCREEN_HEIGHT-1);

  typedef enum logic [2:0] {
    IDLE, DIFF, MUL, CLASSIFY, OUTPUT
  } state_t;

  state_t state, state_nx;

  logic signed [DW-1:0] v0_q [3];
  logic signed [DW-1:0] v1_q [3];
  logic signed [DW-1:0] v2_q [3];
  logic                 last_q;
  logic                 clr_q;
  logic signed [DW:0]   ea_q [3];
  logic signed [DW:0]   eb_q [3];
  logic signed [DW:0]   dy20_q, dx20_q, dy10_q;
  logic signed [DW-1:0] minx_q, maxx_q;
  logic signed [DW-1:0] miny_q, maxy_q;
  logic signed [PW-1:0] p0_q, p1_q;
  logic signed [AW-1:0] area;
  logic                 culled;

  function automatic logic signed [DW:0] dif(
    input logic signed [DW-1:0] a,
    input logic signed [DW-1:0] b
  );
    return (DW+1)'(a) - (DW+1)'(b);
  endfunction

  function automatic logic signed [DW-1:0] min3(
    input logic signed [DW-1:0] a,
    input logic signed [DW-1:0] b,
    input logic signed [DW-1:0] c
  );
    logic signed [DW-1:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic logic signed [DW-1:0] max3(
    input logic signed [DW-1:0] a,
    input logic signed [DW-1:0] b,
    input logic signed [DW-1:0] c
  );
    logic signed [DW-1:0] m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  function automatic logic [DW-1:0] clamp(
    input logic signed [DW-1:0] v,
    input logic signed [DW-1:0] lim
  );
    if (v[DW-1])   return '0;
    else if (v > lim) return lim;
    else           return v;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    bus.o_ready = 1'b0;
    unique case (state)
      IDLE: begin
        bus.o_ready = 1'b1;
        if (bus.i_triangle_dv) state_nx = DIFF;
      end
      DIFF:     state_nx = MUL;
      MUL:      state_nx = CLASSIFY;
      CLASSIFY: state_nx = culled ? IDLE : OUTPUT;
      OUTPUT:   if (bus.i_ready) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // bbox tests use the unclamped extents so partly visible
  // triangles always survive
  always_comb begin
    area   = AW'(p0_q) - AW'(p1_q);
    culled = (area == '0)
          || ((CULL_BACKFACE != 0) && area[AW-1])
          || maxx_q[DW-1] || (minx_q > XMAX)
          || maxy_q[DW-1] || (miny_q > YMAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        v0_q[i] <= '0;
        v1_q[i] <= '0;
        v2_q[i] <= '0;
        ea_q[i] <= '0;
        eb_q[i] <= '0;
        bus.o_v0[i] <= '0;
        bus.o_v1[i] <= '0;
        bus.o_v2[i] <= '0;
        bus.o_edge_a[i] <= '0;
        bus.o_edge_b[i] <= '0;
      end
      last_q  <= 1'b0;
      clr_q   <= 1'b0;
      dy20_q  <= '0;
      dx20_q  <= '0;
      dy10_q  <= '0;
      minx_q  <= '0;
      maxx_q  <= '0;
      miny_q  <= '0;
      maxy_q  <= '0;
      p0_q    <= '0;
      p1_q    <= '0;
      bus.o_area       <= '0;
      bus.o_bb_min_x   <= '0;
      bus.o_bb_max_x   <= '0;
      bus.o_bb_min_y   <= '0;
      bus.o_bb_max_y   <= '0;
      bus.o_dv         <= 1'b0;
      bus.o_last       <= 1'b0;
      bus.o_done       <= 1'b0;
      bus.o_cull_count <= '0;
    end else begin
      bus.o_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.i_triangle_dv) begin
            v0_q   <= bus.i_v0;
            v1_q   <= bus.i_v1;
            v2_q   <= bus.i_v2;
            last_q <= bus.i_triangle_last;
            // a new model starts with a fresh cull count
            if (clr_q) begin
              bus.o_cull_count <= '0;
              clr_q <= 1'b0;
            end
          end
        end
        DIFF: begin
          ea_q[0] <= dif(v0_q[1], v1_q[1]);
          ea_q[1] <= dif(v1_q[1], v2_q[1]);
          ea_q[2] <= dif(v2_q[1], v0_q[1]);
          eb_q[0] <= dif(v1_q[0], v0_q[0]);
          eb_q[1] <= dif(v2_q[0], v1_q[0]);
          eb_q[2] <= dif(v0_q[0], v2_q[0]);
          dy20_q  <= dif(v2_q[1], v0_q[1]);
          dx20_q  <= dif(v2_q[0], v0_q[0]);
          dy10_q  <= dif(v1_q[1], v0_q[1]);
          minx_q  <= min3(v0_q[0], v1_q[0], v2_q[0]);
          maxx_q  <= max3(v0_q[0], v1_q[0], v2_q[0]);
          miny_q  <= min3(v0_q[1], v1_q[1], v2_q[1]);
          maxy_q  <= max3(v0_q[1], v1_q[1], v2_q[1]);
        end
        MUL: begin
          p0_q <= PW'(eb_q[0]) * PW'(dy20_q);
          p1_q <= PW'(dx20_q) * PW'(dy10_q);
        end
        CLASSIFY: begin
          if (culled) begin
            if (bus.o_cull_count != 16'hFFFF)
              bus.o_cull_count <= bus.o_cull_count + 16'd1;
            if (last_q) begin
              bus.o_done <= 1'b1;
              clr_q      <= 1'b1;
            end
          end else begin
            bus.o_v0       <= v0_q;
            bus.o_v1       <= v1_q;
            bus.o_v2       <= v2_q;
            bus.o_edge_a   <= ea_q;
            bus.o_edge_b   <= eb_q;
            bus.o_area     <= area;
            bus.o_bb_min_x <= XW'(clamp(minx_q, XMAX));
            bus.o_bb_max_x <= XW'(clamp(maxx_q, XMAX));
            bus.o_bb_min_y <= YW'(clamp(miny_q, YMAX));
            bus.o_bb_max_y <= YW'(clamp(maxy_q, YMAX));
            bus.o_dv       <= 1'b1;
            bus.o_last     <= last_q;
          end
        end
        OUTPUT: begin
          if (bus.i_ready) begin
            bus.o_dv   <= 1'b0;
            bus.o_last <= 1'b0;
            if (last_q) begin
              bus.o_done <= 1'b1;
              clr_q      <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_triangle_setup.sv
// Bench for triangle_setup: directed corner cases plus random
// triangles checked against an arithmetic reference model.
module tb_triangle_setup;
  localparam int DW = 12;
  localparam int W  = 320;
  localparam int H  = 320;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  triangle_setup_if #(.DATAWIDTH(DW)) bus1 ();
  triangle_setup_if #(.DATAWIDTH(DW)) bus2 ();

  triangle_setup #(.DATAWIDTH(DW), .CULL_BACKFACE(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave)
  );
  triangle_setup #(.DATAWIDTH(DW), .CULL_BACKFACE(0)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2.slave)
  );

  int total = 0;
  int bad   = 0;
  int m_cnt = 0;
  bit m_clr = 1'b0;

  task automatic ref_model(
    input int x[3], input int y[3], input bit cbf,
    output bit culled, output int area,
    output int ea[3], output int eb[3], output int bb[4]
  );
    int mnx, mxx, mny, mxy;
    area = (x[1]-x[0])*(y[2]-y[0]) - (x[2]-x[0])*(y[1]-y[0]);
    mnx = x[0]; mxx = x[0]; mny = y[0]; mxy = y[0];
    for (int i = 0; i < 3; i++) begin
      ea[i] = y[i] - y[(i+1)%3];
      eb[i] = x[(i+1)%3] - x[i];
      if (x[i] < mnx) mnx = x[i];
      if (x[i] > mxx) mxx = x[i];
      if (y[i] < mny) mny = y[i];
      if (y[i] > mxy) mxy = y[i];
    end
    culled = (area == 0) || (cbf && area < 0) || (mxx < 0)
          || (mnx > W-1) || (mxy < 0) || (mny > H-1);
    bb[0] = mnx < 0 ? 0 : (mnx > W-1 ? W-1 : mnx);
    bb[1] = mxx < 0 ? 0 : (mxx > W-1 ? W-1 : mxx);
    bb[2] = mny < 0 ? 0 : (mny > H-1 ? H-1 : mny);
    bb[3] = mxy < 0 ? 0 : (mxy > H-1 ? H-1 : mxy);
  endtask

  task automatic model_accept();
    if (m_clr) begin m_cnt = 0; m_clr = 1'b0; end
  endtask

  task automatic model_retire(input bit culled, input bit last);
    if (culled && m_cnt < 65535) m_cnt++;
    if (last) m_clr = 1'b1;
  endtask

  task automatic set_in(input int sel, input int x[3], input int y[3],
                        input int z[3], input bit last, input bit dv);
    if (sel == 1) begin
      bus1.i_v0 = '{DW'(x[0]), DW'(y[0]), DW'(z[0])};
      bus1.i_v1 = '{DW'(x[1]), DW'(y[1]), DW'(z[1])};
      bus1.i_v2 = '{DW'(x[2]), DW'(y[2]), DW'(z[2])};
      bus1.i_triangle_last = last;
      bus1.i_triangle_dv   = dv;
    end else begin
      bus2.i_v0 = '{DW'(x[0]), DW'(y[0]), DW'(z[0])};
      bus2.i_v1 = '{DW'(x[1]), DW'(y[1]), DW'(z[1])};
      bus2.i_v2 = '{DW'(x[2]), DW'(y[2]), DW'(z[2])};
      bus2.i_triangle_last = last;
      bus2.i_triangle_dv   = dv;
    end
  endtask

  // lat = rising edges after accept until o_dv or o_ready is seen
  task automatic send(input int sel, input int x[3], input int y[3],
                      input int z[3], input bit last,
                      output int lat, output bit seen);
    int k;
    logic rd, dv;
    k = 0;
    rd = (sel == 1) ? bus1.o_ready : bus2.o_ready;
    while (rd !== 1'b1 && k < 30) begin
      @(posedge clk); @(negedge clk); k++;
      rd = (sel == 1) ? bus1.o_ready : bus2.o_ready;
    end
    if (k >= 30) begin
      total++; bad++;
      $display("FAIL accept_timeout got_ready=%0b exp=1", rd);
    end
    set_in(sel, x, y, z, last, 1'b1);
    @(posedge clk); @(negedge clk);
    set_in(sel, x, y, z, ~last, 1'b0);
    lat = 0; seen = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); @(negedge clk);
      dv = (sel == 1) ? bus1.o_dv : bus2.o_dv;
      rd = (sel == 1) ? bus1.o_ready : bus2.o_ready;
      if (dv === 1'b1) begin seen = 1'b1; lat = c; break; end
      if (rd === 1'b1) begin lat = c; break; end
    end
  endtask

  task automatic test_reset();
    int z[3];
    z = '{0, 0, 0};
    rst = 1'b1;
    bus1.i_ready = 1'b1; bus2.i_ready = 1'b1;
    set_in(1, z, z, z, 1'b0, 1'b0);
    set_in(2, z, z, z, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_cnt = 0; m_clr = 1'b0;
    total++; if (bus1.o_ready !== 1'b1) begin bad++;
      $display("FAIL reset_ready got=%0b exp=1", bus1.o_ready); end
    total++; if (bus1.o_dv !== 1'b0) begin bad++;
      $display("FAIL reset_dv got=%0b exp=0", bus1.o_dv); end
    total++; if (bus1.o_cull_count !== 16'd0) begin bad++;
      $display("FAIL reset_cull got=%0d exp=0", bus1.o_cull_count); end
    total++; if (bus1.o_done !== 1'b0 || bus1.o_last !== 1'b0) begin bad++;
      $display("FAIL reset_done_last got=%0b%0b exp=00",
               bus1.o_done, bus1.o_last); end
    total++; if (bus1.o_area !== 27'sd0) begin bad++;
      $display("FAIL reset_area got=%0d exp=0", bus1.o_area); end
  endtask

  task automatic test_ccw();
    int x[3], y[3], z[3], ea[3], eb[3], bb[4], area, lat;
    bit cul, seen;
    x = '{10, 20, 10}; y = '{10, 10, 30}; z = '{100, 2000, 4095};
    ref_model(x, y, 1'b1, cul, area, ea, eb, bb);
    bus1.i_ready = 1'b1;
    model_accept();
    send(1, x, y, z, 1'b0, lat, seen);
    total++; if (!seen || lat != 3) begin bad++;
      $display("FAIL ccw_latency got=%0d seen=%0b exp=3", lat, seen); end
    total++; if (bus1.o_area !== 27'sd200) begin bad++;
      $display("FAIL ccw_area got=%0d exp=200", bus1.o_area); end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (bus1.o_edge_a[i] !== 13'(ea[i]) || bus1.o_edge_b[i] !== 13'(eb[i])) begin
        bad++;
        $display("FAIL ccw_edge%0d got=%0d,%0d exp=%0d,%0d", i,
                 bus1.o_edge_a[i], bus1.o_edge_b[i], ea[i], eb[i]);
      end
    end
    total++;
    if (bus1.o_bb_min_x !== 9'd10 || bus1.o_bb_max_x !== 9'd20 ||
        bus1.o_bb_min_y !== 9'd10 || bus1.o_bb_max_y !== 9'd30) begin
      bad++;
      $display("FAIL ccw_bbox got=%0d..%0d,%0d..%0d exp=10..20,10..30",
               bus1.o_bb_min_x, bus1.o_bb_max_x,
               bus1.o_bb_min_y, bus1.o_bb_max_y);
    end
    total++;
    if (bus1.o_v1[0] !== 12'sd20 || bus1.o_v2[1] !== 12'sd30 ||
        bus1.o_v2[2] !== 12'(z[2]) || bus1.o_last !== 1'b0) begin
      bad++;
      $display("FAIL ccw_copy got=%0d,%0d,%0d,%0b exp=20,30,%0d,0",
               bus1.o_v1[0], bus1.o_v2[1], bus1.o_v2[2], bus1.o_last, z[2]);
    end
    @(posedge clk); @(negedge clk);
    model_retire(1'b0, 1'b0);
    total++;
    if (bus1.o_dv !== 1'b0 || bus1.o_ready !== 1'b1 || bus1.o_done !== 1'b0) begin
      bad++;
      $display("FAIL ccw_handshake got dv=%0b rdy=%0b done=%0b exp=0,1,0",
               bus1.o_dv, bus1.o_ready, bus1.o_done);
    end
  endtask

  task automatic test_backface();
    int x[3], y[3], z[3], lat;
    bit seen;
    x = '{10, 10, 20}; y = '{10, 30, 10}; z = '{0, 0, 0};
    model_accept();
    send(1, x, y, z, 1'b0, lat, seen);
    model_retire(1'b1, 1'b0);
    total++; if (seen || lat != 3) begin bad++;
      $display("FAIL backface_cull got seen=%0b lat=%0d exp=0,3", seen, lat); end
    total++; if (bus1.o_cull_count !== 16'(m_cnt)) begin bad++;
      $display("FAIL backface_count got=%0d exp=%0d", bus1.o_cull_count, m_cnt); end
    bus2.i_ready = 1'b1;
    send(2, x, y, z, 1'b0, lat, seen);
    total++; if (!seen || bus2.o_area !== -27'sd200) begin bad++;
      $display("FAIL nocull_area got seen=%0b area=%0d exp=1,-200",
               seen, bus2.o_area); end
    @(posedge clk); @(negedge clk);
    total++; if (bus2.o_dv !== 1'b0 || bus2.o_cull_count !== 16'd0) begin bad++;
      $display("FAIL nocull_done got dv=%0b cnt=%0d exp=0,0",
               bus2.o_dv, bus2.o_cull_count); end
  endtask

  task automatic test_collinear();
    int x[3], y[3], z[3], lat;
    bit seen;
    x = '{0, 5, 10}; y = '{0, 5, 10}; z = '{1, 2, 3};
    model_accept();
    send(1, x, y, z, 1'b0, lat, seen);
    model_retire(1'b1, 1'b0);
    total++; if (seen || bus1.o_cull_count !== 16'(m_cnt)) begin bad++;
      $display("FAIL collinear got seen=%0b cnt=%0d exp=0,%0d",
               seen, bus1.o_cull_count, m_cnt); end
  endtask

  task automatic test_clamp();
    int x[3], y[3], z[3], lat;
    bit seen;
    x = '{-50, 400, -50}; y = '{-50, -50, 400}; z = '{7, 7, 7};
    model_accept();
    send(1, x, y, z, 1'b0, lat, seen);
    total++;
    if (!seen || bus1.o_bb_min_x !== 9'd0 || bus1.o_bb_max_x !== 9'd319 ||
        bus1.o_bb_min_y !== 9'd0 || bus1.o_bb_max_y !== 9'd319) begin
      bad++;
      $display("FAIL clamp_bbox got seen=%0b %0d..%0d,%0d..%0d exp=1 0..319,0..319",
               seen, bus1.o_bb_min_x, bus1.o_bb_max_x,
               bus1.o_bb_min_y, bus1.o_bb_max_y);
    end
    total++; if (bus1.o_area !== 27'sd202500) begin bad++;
      $display("FAIL clamp_area got=%0d exp=202500", bus1.o_area); end
    @(posedge clk); @(negedge clk);
    model_retire(1'b0, 1'b0);
  endtask

  task automatic test_offscreen_last();
    int x[3], y[3], z[3], lat;
    bit seen;
    x = '{330, 340, 330}; y = '{10, 10, 30}; z = '{0, 0, 0};
    model_accept();
    send(1, x, y, z, 1'b1, lat, seen);
    model_retire(1'b1, 1'b1);
    total++;
    if (seen || bus1.o_done !== 1'b1 || bus1.o_last !== 1'b0) begin
      bad++;
      $display("FAIL offscreen_done got seen=%0b done=%0b last=%0b exp=0,1,0",
               seen, bus1.o_done, bus1.o_last);
    end
    total++; if (bus1.o_cull_count !== 16'(m_cnt)) begin bad++;
      $display("FAIL offscreen_count got=%0d exp=%0d", bus1.o_cull_count, m_cnt); end
    @(posedge clk); @(negedge clk);
    total++; if (bus1.o_done !== 1'b0) begin bad++;
      $display("FAIL offscreen_pulse got=%0b exp=0", bus1.o_done); end
  endtask

  task automatic test_backpressure();
    int x[3], y[3], z[3], lat, sa, sx;
    bit seen, ok;
    x = '{100, 150, 100}; y = '{100, 100, 180}; z = '{5, 6, 7};
    bus1.i_ready = 1'b0;
    model_accept();
    send(1, x, y, z, 1'b0, lat, seen);
    total++; if (!seen || bus1.o_cull_count !== 16'(m_cnt)) begin bad++;
      $display("FAIL bp_emit_clear got seen=%0b cnt=%0d exp=1,%0d",
               seen, bus1.o_cull_count, m_cnt); end
    sa = int'(bus1.o_area); sx = int'(bus1.o_bb_max_y);
    ok = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); @(negedge clk);
      if (bus1.o_dv !== 1'b1 || bus1.o_ready !== 1'b0 ||
          int'(bus1.o_area) != sa || int'(bus1.o_bb_max_y) != sx ||
          bus1.o_edge_b[0] !== 13'sd50 || bus1.o_v0[0] !== 12'sd100) ok = 1'b0;
    end
    total++; if (!ok || sa != 4000 || sx != 180) begin bad++;
      $display("FAIL bp_hold got ok=%0b area=%0d maxy=%0d exp=1,4000,180",
               ok, sa, sx); end
    bus1.i_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    model_retire(1'b0, 1'b0);
    total++; if (bus1.o_dv !== 1'b0 || bus1.o_ready !== 1'b1) begin bad++;
      $display("FAIL bp_release got dv=%0b rdy=%0b exp=0,1",
               bus1.o_dv, bus1.o_ready); end
  endtask

  function automatic int rnd_coord();
    if ($urandom_range(0, 3) == 0)
      return int'($urandom_range(0, 4095)) - 2048;
    return int'($urandom_range(0, 440)) - 60;
  endfunction

  task automatic test_random();
    int x[3], y[3], z[3], ea[3], eb[3], bb[4], area, lat, w;
    bit cul, seen, last, ok;
    for (int n = 0; n < 60; n++) begin
      for (int i = 0; i < 3; i++) begin
        x[i] = rnd_coord(); y[i] = rnd_coord();
        z[i] = int'($urandom_range(0, 4095));
      end
      last = ($urandom_range(0, 5) == 0);
      w = int'($urandom_range(0, 2));
      bus1.i_ready = (w == 0);
      ref_model(x, y, 1'b1, cul, area, ea, eb, bb);
      model_accept();
      send(1, x, y, z, last, lat, seen);
      total++; if (seen !== !cul || lat != 3) begin bad++;
        $display("FAIL rnd%0d_class got seen=%0b lat=%0d exp=%0b,3",
                 n, seen, lat, !cul); end
      if (!cul) begin
        ok = (bus1.o_area === 27'(area)) && (bus1.o_last === last) &&
             (bus1.o_bb_min_x === 9'(bb[0])) && (bus1.o_bb_max_x === 9'(bb[1])) &&
             (bus1.o_bb_min_y === 9'(bb[2])) && (bus1.o_bb_max_y === 9'(bb[3])) &&
             (bus1.o_v0[0] === 12'(x[0])) && (bus1.o_v1[1] === 12'(y[1])) &&
             (bus1.o_v2[2] === 12'(z[2])) && (bus1.o_done === 1'b0);
        for (int i = 0; i < 3; i++)
          if (bus1.o_edge_a[i] !== 13'(ea[i]) || bus1.o_edge_b[i] !== 13'(eb[i]))
            ok = 1'b0;
        total++; if (!ok || bus1.o_cull_count !== 16'(m_cnt)) begin bad++;
          $display("FAIL rnd%0d_data got area=%0d bb=%0d..%0d,%0d..%0d cnt=%0d exp area=%0d bb=%0d..%0d,%0d..%0d cnt=%0d",
                   n, bus1.o_area, bus1.o_bb_min_x, bus1.o_bb_max_x,
                   bus1.o_bb_min_y, bus1.o_bb_max_y, bus1.o_cull_count,
                   area, bb[0], bb[1], bb[2], bb[3], m_cnt); end
        repeat (w) begin @(posedge clk); @(negedge clk); end
        bus1.i_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        model_retire(1'b0, last);
        total++;
        if (bus1.o_dv !== 1'b0 || bus1.o_ready !== 1'b1 || bus1.o_done !== last) begin
          bad++;
          $display("FAIL rnd%0d_hs got dv=%0b rdy=%0b done=%0b exp=0,1,%0b",
                   n, bus1.o_dv, bus1.o_ready, bus1.o_done, last);
        end
      end else begin
        model_retire(1'b1, last);
        total++;
        if (bus1.o_cull_count !== 16'(m_cnt) || bus1.o_done !== last) begin
          bad++;
          $display("FAIL rnd%0d_cull got cnt=%0d done=%0b exp=%0d,%0b",
                   n, bus1.o_cull_count, bus1.o_done, m_cnt, last);
        end
      end
      bus1.i_ready = 1'b1;
    end
  endtask

  task automatic test_reset_mid();
    int x[3], y[3], z[3];
    bit ok;
    x = '{10, 20, 10}; y = '{10, 10, 30}; z = '{1, 1, 1};
    bus1.i_ready = 1'b1;
    set_in(1, x, y, z, 1'b1, 1'b1);
    @(posedge clk); @(negedge clk);
    bus1.i_triangle_dv = 1'b0;
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    m_cnt = 0; m_clr = 1'b0;
    ok = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (bus1.o_dv !== 1'b0 || bus1.o_done !== 1'b0) ok = 1'b0;
      @(posedge clk); @(negedge clk);
    end
    total++; if (!ok) begin bad++;
      $display("FAIL rstmid_quiet got dv=%0b done=%0b exp=0,0",
               bus1.o_dv, bus1.o_done); end
    total++;
    if (bus1.o_ready !== 1'b1 || bus1.o_area !== 27'sd0 ||
        bus1.o_v1[0] !== 12'sd0 || bus1.o_cull_count !== 16'd0 ||
        bus1.o_bb_max_y !== 9'd0) begin
      bad++;
      $display("FAIL rstmid_outputs got rdy=%0b area=%0d v1x=%0d cnt=%0d exp=1,0,0,0",
               bus1.o_ready, bus1.o_area, bus1.o_v1[0], bus1.o_cull_count);
    end
  endtask

  initial begin
    test_reset();
    test_ccw();
    test_backface();
    test_collinear();
    test_clamp();
    test_offscreen_last();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
